// File: rtl/dram_slot_sequencer_pkg.sv
// Shared definitions for the DRAM slot sequencer and the DRAM datapath.
//   PHASE_W      : width of the slot phase counter (8 phases per slot)
//   PHASE_LAST   : final phase of a slot; requests are accepted here
//   slot_state_e : handshake FSM state encoding
//   is_busy()    : true for every state that has an access in flight
package dram_slot_sequencer_pkg;

    localparam int PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PHASE_LAST = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_HOLD   = 3'd4
    } slot_state_e;

    function automatic logic is_busy(input slot_state_e s);
        return (s != ST_IDLE);
    endfunction

endpackage

// File: rtl/dram_slot_sequencer_phase_counter.sv
// Slot phase counter and video-address slot flag.
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_ce    : pixel tick enable; the phase only moves on ticks
//   o_phase : current slot phase, 0..7, wraps 7 -> 0
//   o_ce5   : high on odd phases
module dram_phase_counter
    import dram_slot_sequencer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_ce,
    output logic [PHASE_W-1:0] o_phase,
    output logic               o_ce5
);

    logic [PHASE_W-1:0] r_phase;
    logic [PHASE_W-1:0] w_phase_next;
    logic               r_ce5;

    assign w_phase_next = r_phase + PHASE_W'(1);

    // ce5 is loaded from the next phase so it lines up with o_phase in the
    // same clock instead of trailing it by one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_phase <= '0;
            r_ce5   <= 1'b0;
        end else if (i_ce) begin
            r_phase <= w_phase_next;
            r_ce5   <= w_phase_next[0];
        end
    end

    assign o_phase = r_phase;
    assign o_ce5   = r_ce5;

endmodule

// File: rtl/dram_slot_sequencer.sv
// DRAM slot sequencer: hands one CPU access per 8-phase slot to the DRAM,
// producing the read-capture and write strobes inside the slot.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   ce      : pixel tick enable; phase advance and strobes are qualified by it
//   cpu_req : level request (4-phase handshake)
//   cpu_wr  : 1 = write, 0 = read; sampled when the request is accepted
//   phase   : current slot phase
//   ce5     : video-address slot (odd phases)
//   ce2Hd2  : read-capture strobe at CAP_PHASE of the access slot
//   ce2Hd3  : write strobe at WR_PHASE of the access slot, writes only
//   ack     : one-clock access-complete pulse
//   busy    : access in flight or handshake not yet returned to idle
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no access; wait for cpu_req on a phase-7 tick
// ST_ARMED  | request accepted, waiting for the phase-0 tick
// ST_ACCESS | slot running; capture at CAP_PHASE, write at WR_PHASE
// ST_DONE   | one clock, drives ack
// ST_HOLD   | wait for cpu_req to drop before another request is accepted
module dram_slot_sequencer
    import dram_slot_sequencer_pkg::*;
#(
    parameter int CAP_PHASE = 1,
    parameter int WR_PHASE  = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               cpu_req,
    input  logic               cpu_wr,
    output logic [PHASE_W-1:0] phase,
    output logic               ce5,
    output logic               ce2Hd2,
    output logic               ce2Hd3,
    output logic               ack,
    output logic               busy
);

    localparam logic [PHASE_W-1:0] CAP_P = PHASE_W'(CAP_PHASE);
    localparam logic [PHASE_W-1:0] WR_P  = PHASE_W'(WR_PHASE);

    slot_state_e        r_state;
    slot_state_e        w_state_next;
    logic               w_accept;
    logic               r_wr;
    logic [PHASE_W-1:0] w_phase;
    logic               w_ce5;

    dram_phase_counter u_phase (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_ce    (ce),
        .o_phase (w_phase),
        .o_ce5   (w_ce5)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr <= 1'b0;
        end else if (w_accept) begin
            r_wr <= cpu_wr;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (ce && cpu_req && (w_phase == PHASE_LAST)) begin
                    w_state_next = ST_ARMED;
                    w_accept     = 1'b1;
                end
            end
            ST_ARMED: begin
                if (ce && (w_phase == '0)) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (ce && (w_phase == WR_P)) begin
                    w_state_next = ST_DONE;
                end
            end
            // DONE lasts exactly one clock regardless of ce so ack stays one clock wide.
            ST_DONE: begin
                w_state_next = ST_HOLD;
            end
            // Holding here while cpu_req stays high keeps a held request from
            // being accepted again at the next phase 7.
            ST_HOLD: begin
                if (!cpu_req) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Strobes decode directly from state, phase and ce so that a reset, which
    // forces IDLE, kills any strobe in the same instant.
    assign ce2Hd2 = ce && (r_state == ST_ACCESS) && (w_phase == CAP_P);
    assign ce2Hd3 = ce && (r_state == ST_ACCESS) && (w_phase == WR_P) && r_wr;
    assign ack    = (r_state == ST_DONE);
    assign busy   = is_busy(r_state);
    assign phase  = w_phase;
    assign ce5    = w_ce5;

endmodule

// File: tb/tb_dram_slot_sequencer.sv
module tb_dram_slot_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce;
    logic       cpu_req;
    logic       cpu_wr;
    logic [2:0] phase;
    logic       ce5;
    logic       ce2Hd2;
    logic       ce2Hd3;
    logic       ack;
    logic       busy;

    int         vecs = 0;
    int         errs = 0;
    logic [2:0] m_phase;
    int         n_hd2, n_hd3, n_ack;
    logic [2:0] p_hd2, p_hd3, p_ack;

    dram_slot_sequencer #(.CAP_PHASE(1), .WR_PHASE(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ce      (ce),
        .cpu_req (cpu_req),
        .cpu_wr  (cpu_wr),
        .phase   (phase),
        .ce5     (ce5),
        .ce2Hd2  (ce2Hd2),
        .ce2Hd3  (ce2Hd3),
        .ack     (ack),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic clr();
        n_hd2 = 0; n_hd3 = 0; n_ack = 0;
        p_hd2 = '0; p_hd3 = '0; p_ack = '0;
    endtask

    // One clock: sample at the falling edge, advance the phase model at the
    // rising edge, return 1 time unit after it.
    task automatic clk1();
        @(negedge clk);
        vecs++;
        if (phase !== m_phase) begin
            errs++;
            $display("FAIL phase: got %0d expected %0d at %0t", phase, m_phase, $time);
        end
        vecs++;
        if (ce5 !== m_phase[0]) begin
            errs++;
            $display("FAIL ce5: got %b expected %b at %0t", ce5, m_phase[0], $time);
        end
        if (ce2Hd2 === 1'b1) begin n_hd2++; p_hd2 = m_phase; end
        if (ce2Hd3 === 1'b1) begin n_hd3++; p_hd3 = m_phase; end
        if (ack === 1'b1)    begin n_ack++; p_ack = m_phase; end
        @(posedge clk);
        if (ce) m_phase = m_phase + 3'd1;
        #1;
    endtask

    task automatic wait_to(input logic [2:0] p);
        for (int i = 0; i < 8; i++) begin
            if (m_phase != p) clk1();
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; ce = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
        @(posedge clk); #1;
        m_phase = '0;
        reset_n = 1'b1;
    endtask

    task automatic chk_counts(input string tag, input int e_hd2, input int e_hd3, input int e_ack);
        vecs++;
        if (n_hd2 != e_hd2) begin errs++; $display("FAIL %s ce2Hd2 count: got %0d expected %0d", tag, n_hd2, e_hd2); end
        vecs++;
        if (n_hd3 != e_hd3) begin errs++; $display("FAIL %s ce2Hd3 count: got %0d expected %0d", tag, n_hd3, e_hd3); end
        vecs++;
        if (n_ack != e_ack) begin errs++; $display("FAIL %s ack count: got %0d expected %0d", tag, n_ack, e_ack); end
    endtask

    task automatic chk_busy(input string tag, input logic e);
        vecs++;
        if (busy !== e) begin errs++; $display("FAIL %s busy: got %b expected %b", tag, busy, e); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ce = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b1;
        #2;
        vecs++;
        if ({phase, ce5, ce2Hd2, ce2Hd3, ack, busy} !== 8'b0) begin
            errs++;
            $display("FAIL reset outputs: got phase=%0d ce5=%b hd2=%b hd3=%b ack=%b busy=%b expected all 0",
                     phase, ce5, ce2Hd2, ce2Hd3, ack, busy);
        end
        repeat (3) @(posedge clk);
        #1;
        vecs++;
        if (phase !== 3'd0) begin errs++; $display("FAIL reset hold phase: got %0d expected 0", phase); end
        ce = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
        m_phase = '0;
        reset_n = 1'b1;
        clk1();
        clk1();
        ce = 1'b1;
        clk1();
        clk1();
        vecs++;
        if (phase !== 3'd2) begin errs++; $display("FAIL reset first tick phase: got %0d expected 2", phase); end
    endtask

    task automatic test_read();
        do_reset();
        ce = 1'b1;
        wait_to(3'd3);
        cpu_req = 1'b1; cpu_wr = 1'b0;
        clr();
        wait_to(3'd7);
        chk_busy("read pre-accept", 1'b0);
        clk1();
        chk_busy("read armed", 1'b1);
        repeat (8) clk1();
        chk_counts("read", 1, 0, 1);
        vecs++;
        if (p_hd2 !== 3'd1) begin errs++; $display("FAIL read ce2Hd2 phase: got %0d expected 1", p_hd2); end
        vecs++;
        if (p_ack !== 3'd3) begin errs++; $display("FAIL read ack phase: got %0d expected 3", p_ack); end
        chk_busy("read hold", 1'b1);
        cpu_req = 1'b0;
        clk1();
        chk_busy("read release", 1'b0);
    endtask

    task automatic test_write();
        do_reset();
        ce = 1'b1;
        wait_to(3'd7);
        cpu_req = 1'b1; cpu_wr = 1'b1;
        clr();
        repeat (32) clk1();
        chk_counts("write", 1, 1, 1);
        vecs++;
        if ({p_hd2, p_hd3, p_ack} !== {3'd1, 3'd2, 3'd3}) begin
            errs++;
            $display("FAIL write strobe phases: got hd2=%0d hd3=%0d ack=%0d expected 1 2 3", p_hd2, p_hd3, p_ack);
        end
        chk_busy("write hold", 1'b1);
        cpu_req = 1'b0; cpu_wr = 1'b0;
        clk1();
        chk_busy("write release", 1'b0);
    endtask

    task automatic test_back_to_back();
        ce = 1'b1;
        cpu_req = 1'b1; cpu_wr = 1'b0;
        clr();
        repeat (40) clk1();
        chk_counts("held 40", 1, 0, 1);
        chk_busy("held 40", 1'b1);
        cpu_req = 1'b0;
        clk1();
        chk_busy("held release", 1'b0);
        cpu_req = 1'b1;
        clr();
        clk1();
        wait_to(3'd0);
        chk_busy("second armed", 1'b1);
        chk_counts("second pre-slot", 0, 0, 0);
        clk1();
        clk1();
        vecs++;
        if (n_hd2 != 1 || p_hd2 !== 3'd1) begin
            errs++;
            $display("FAIL second ce2Hd2: got count %0d phase %0d expected 1 at 1", n_hd2, p_hd2);
        end
        clk1();
        clk1();
        vecs++;
        if (n_ack != 1 || p_ack !== 3'd3) begin
            errs++;
            $display("FAIL second ack: got count %0d phase %0d expected 1 at 3", n_ack, p_ack);
        end
        cpu_req = 1'b0;
        clk1();
        chk_busy("second release", 1'b0);
    endtask

    task automatic test_ce_sparse();
        do_reset();
        cpu_req = 1'b1; cpu_wr = 1'b1;
        clr();
        for (int k = 0; k < 120; k++) begin
            ce = (k % 4 == 0);
            clk1();
        end
        chk_counts("sparse ce", 1, 1, 1);
        vecs++;
        if ({p_hd2, p_hd3, p_ack} !== {3'd1, 3'd2, 3'd3}) begin
            errs++;
            $display("FAIL sparse strobe phases: got hd2=%0d hd3=%0d ack=%0d expected 1 2 3", p_hd2, p_hd3, p_ack);
        end
        vecs++;
        if (m_phase !== 3'd6 || phase !== 3'd6) begin
            errs++;
            $display("FAIL sparse final phase: got %0d expected 6", phase);
        end
        ce = 1'b0; cpu_req = 1'b0;
        clk1();
        chk_busy("sparse release", 1'b0);
    endtask

    task automatic test_freeze();
        do_reset();
        ce = 1'b1;
        wait_to(3'd7);
        cpu_req = 1'b1; cpu_wr = 1'b1;
        clk1();
        clk1();
        ce = 1'b0;
        clr();
        repeat (20) clk1();
        chk_counts("frozen", 0, 0, 0);
        chk_busy("frozen", 1'b1);
        ce = 1'b1;
        repeat (3) clk1();
        chk_counts("unfrozen", 1, 1, 1);
        cpu_req = 1'b0;
        clk1();
        chk_busy("unfrozen release", 1'b0);
    endtask

    task automatic test_reset_abort();
        do_reset();
        ce = 1'b1;
        wait_to(3'd7);
        cpu_req = 1'b1; cpu_wr = 1'b1;
        clk1();
        clk1();
        #1;
        vecs++;
        if (ce2Hd2 !== 1'b1) begin errs++; $display("FAIL abort pre-reset ce2Hd2: got %b expected 1", ce2Hd2); end
        reset_n = 1'b0;
        #1;
        vecs++;
        if ({phase, ce5, ce2Hd2, ce2Hd3, ack, busy} !== 8'b0) begin
            errs++;
            $display("FAIL abort async reset: got phase=%0d ce5=%b hd2=%b hd3=%b ack=%b busy=%b expected all 0",
                     phase, ce5, ce2Hd2, ce2Hd3, ack, busy);
        end
        m_phase = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0;
        clr();
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (16) clk1();
        chk_counts("abort after", 0, 0, 0);
        chk_busy("abort after", 1'b0);
    endtask

    task automatic test_drop();
        do_reset();
        ce = 1'b1;
        wait_to(3'd7);
        cpu_req = 1'b1; cpu_wr = 1'b1;
        clr();
        clk1();
        clk1();
        cpu_req = 1'b0;
        clk1();
        clk1();
        clk1();
        chk_counts("drop", 1, 1, 1);
        vecs++;
        if (p_hd3 !== 3'd2 || p_ack !== 3'd3) begin
            errs++;
            $display("FAIL drop phases: got hd3=%0d ack=%0d expected 2 3", p_hd3, p_ack);
        end
        chk_busy("drop hold", 1'b1);
        clk1();
        chk_busy("drop idle", 1'b0);
    endtask

    initial begin
        reset_n = 1'b0; ce = 1'b0; cpu_req = 1'b0; cpu_wr = 1'b0;
        m_phase = '0;
        clr();
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_ce_sparse();
        test_freeze();
        test_reset_abort();
        test_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dram_slot_sequencer.md
DRAM_SLOT_SEQUENCER -- requirements
Module: dram_slot_sequencer

Interface
REQ-001 Parameter CAP_PHASE, default 1: slot phase in which the CPU read-capture strobe fires; SHALL be odd.
REQ-002 Parameter WR_PHASE, default 2: slot phase in which the write strobe fires; SHALL be even and greater than CAP_PHASE.
REQ-003 Clock and reset are decided: one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  in  1  system clock; all state changes on the rising edge.
REQ-005 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-006 Port: ce  in  1  pixel tick enable; all phase advance and strobes are qualified by ce.
REQ-007 Port: cpu_req  in  1  level request for one DRAM access (4-phase handshake).
REQ-008 Port: cpu_wr  in  1  1 = write, 0 = read; sampled at acceptance.
REQ-009 Port: phase  out  3  current slot phase, 0..7.
REQ-010 Port: ce5  out  1  video-address slot; high on odd phases.
REQ-011 Port: ce2Hd2  out  1  read-capture strobe, one clk wide.
REQ-012 Port: ce2Hd3  out  1  write-enable strobe, one clk wide.
REQ-013 Port: ack  out  1  one-clk pulse: access complete, read data valid.
REQ-014 Port: busy  out  1  high from acceptance until the handshake returns to IDLE.

Function
REQ-015 phase SHALL increment by 1 on each clk with ce=1 and wrap 7->0; it SHALL hold when ce=0.
REQ-016 ce5 SHALL equal phase[0], registered so that it is valid in the same clk as phase.
REQ-017 FSM states: IDLE, ARMED, ACCESS, DONE, HOLD.
REQ-018 IDLE->ARMED when cpu_req=1 on a ce clk with phase=7; cpu_wr SHALL be latched in that clk.
REQ-019 A request arriving at any other phase SHALL wait in IDLE until the next phase=7 ce clk, giving a latency of 1..8 ce ticks to phase 0.
REQ-020 ARMED->ACCESS on the ce clk where phase becomes 0.
REQ-021 In ACCESS, ce2Hd2 SHALL pulse in the ce clk where phase=CAP_PHASE, for both reads and writes; this pulse is the read-modify-write capture.
REQ-022 In ACCESS, ce2Hd3 SHALL pulse in the ce clk where phase=WR_PHASE only if the latched cpu_wr=1.
REQ-023 ce2Hd3 SHALL never pulse outside ACCESS.
REQ-024 ACCESS->DONE after the WR_PHASE ce clk; ack SHALL pulse for exactly one clk on entry to DONE.
REQ-025 DONE->HOLD unconditionally on the next clk.
REQ-026 HOLD->IDLE when cpu_req=0; a request still held at phase 7 SHALL NOT start a second access.
REQ-027 If cpu_req drops during ARMED or ACCESS, the access SHALL complete, including the write, and ack SHALL still pulse; the FSM then passes DONE->HOLD->IDLE.
REQ-028 If ce=0 throughout, the FSM SHALL stay frozen in its current state and emit no strobes.
REQ-029 At most one access SHALL be in flight; busy=1 in ARMED, ACCESS, DONE and HOLD.

Reset
REQ-030 reset_n=0 SHALL asynchronously force phase=0, ce5=0, ce2Hd2=0, ce2Hd3=0, ack=0, busy=0, FSM=IDLE, and latched cpu_wr=0.
REQ-031 A reset during ACCESS SHALL abort the access with no ce2Hd3 pulse and no ack.
REQ-032 After reset_n rises, phase SHALL first advance on the first ce clk.

Structure
REQ-033 The FSM state enum and the phase width constant (3) SHALL live in the shared package used by the DRAM datapath.
REQ-034 The phase counter and ce5 generation SHALL be a sub-module, dram_phase_counter; the FSM and strobe logic SHALL stay in the top module.

Verification
REQ-035 ce=1 every clk; cpu_req=1, cpu_wr=0 raised at phase 3 -> ARMED at phase 7, ce2Hd2 at phase 1, no ce2Hd3, ack at phase 2->3 transition, busy until cpu_req=0.
REQ-036 Write request raised at phase 7 -> ce2Hd2 at phase 1, ce2Hd3 at phase 2, single ack, exactly one ce2Hd3 pulse in 32 cycles.
REQ-037 Request held high for 40 ticks -> exactly one access and one ack; release -> IDLE; re-raise -> second access begins at the next phase 0.
REQ-038 ce asserted every 4th clk -> phase and strobes advance only on ce clks; strobes are 1 clk wide.
REQ-039 reset_n pulsed low at phase 1 of a write -> no ce2Hd3, no ack, phase=0, busy=0 immediately.
REQ-040 cpu_req dropped in phase 1 of a write -> ce2Hd3 at phase 2 and ack still occur; FSM returns to IDLE 2 clks later.
